sim_run_ctrl: RTL and testbench
===============================

SIM_RUN_CTRL -- requirements
Module: sim_run_ctrl

Interface
REQ-001 SHALL have parameter START_DELAY, default 16: idle cycles after run_en is seen before the start pulse.
REQ-002 SHALL have parameter PULSE_LEN, default 4: width of btn_start_input in cycles, 1..255.
REQ-003 SHALL have parameter STOP_THRESH, default 255: consecutive quiet cycles required to declare stop, 1..65535.
REQ-004 SHALL have parameter TIMEOUT, default 1000000: run watchdog limit in cycles, 1..2^32-1.
REQ-005 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port run_en  in  1  level request to execute one run.
REQ-008 SHALL have port pnl_pu_state  in  3  processor state; 3'o0 means halted.
REQ-009 SHALL have port pnl_input_active  in  1  tape input in progress.
REQ-010 SHALL have port pnl_output_active  in  1  tape output in progress.
REQ-011 SHALL have port btn_start_input  out  1  registered start-input button drive.
REQ-012 SHALL have port machine_is_stop  out  1  registered, sticky run-complete flag.
REQ-013 SHALL have port run_timeout  out  1  registered, sticky watchdog flag.
REQ-014 SHALL have port run_state  out  3  current FSM state encoding.
REQ-015 SHALL have port cycle_count  out  32  cycles elapsed since leaving IDLE, saturating.

Function
REQ-016 FSM states SHALL be IDLE=0, DELAY=1, PULSE=2, WAIT_IN=3, RUN=4, DONE=5, TMO=6; encoding 7 is unreachable and SHALL decode to IDLE.
REQ-017 IDLE: with run_en=1, go to DELAY next cycle; clear delay, pulse, quiet and cycle counters.
REQ-018 DELAY: count START_DELAY cycles, then go to PULSE; START_DELAY=0 goes to PULSE after 1 cycle.
REQ-019 PULSE: btn_start_input=1 for exactly PULSE_LEN cycles, then go to WAIT_IN; btn_start_input=0 in every other state.
REQ-020 WAIT_IN: go to RUN on the first cycle pnl_input_active=1.
REQ-021 RUN: the 16-bit quiet counter increments when pnl_pu_state==3'o0, !pnl_input_active and !pnl_output_active all hold; it clears to 0 on any other cycle.
REQ-022 RUN: when the quiet counter equals STOP_THRESH, go to DONE next cycle; machine_is_stop rises on entry to DONE.
REQ-023 cycle_count SHALL increment every cycle in DELAY, PULSE, WAIT_IN and RUN, and saturate at 32'hFFFFFFFF.
REQ-024 In DELAY, PULSE, WAIT_IN or RUN, when cycle_count reaches TIMEOUT, go to TMO; run_timeout rises on entry to TMO.
REQ-025 If the stop threshold and TIMEOUT are reached in the same cycle, go to DONE; run_timeout stays 0.
REQ-026 DONE and TMO hold their flags and freeze cycle_count until run_en=0, then go to IDLE and clear both flags.
REQ-027 run_en=0 in DELAY, PULSE, WAIT_IN or RUN aborts to IDLE next cycle; btn_start_input drops in that same transition.
REQ-028 A run_en toggle inside a single cycle has no effect; only the sampled level is used.
REQ-029 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-030 With reset=1 at a clock edge: state=IDLE; btn_start_input=0, machine_is_stop=0, run_timeout=0, cycle_count=0; all internal counters=0.
REQ-031 Reset SHALL override every other condition, including mid-PULSE, DONE and TMO.

Verification (START_DELAY=4, PULSE_LEN=2, STOP_THRESH=8, TIMEOUT=100)
REQ-032 Nominal run: run_en=1 -> pulse covers cycles 6-7 after run_en is sampled; input_active high 10 cycles; then pu_state=0 held -> machine_is_stop=1 exactly 9 cycles after quiet begins; run_state=5.
REQ-033 Quiet interruption: in RUN, pu_state=0 for 5 cycles, then 3'o1 for 1 cycle, then 0 -> quiet counter restarts from 0; stop is declared only after 8 further quiet cycles.
REQ-034 Watchdog: input_active never rises -> run_timeout=1, run_state=6, cycle_count=100; btn_start_input pulsed exactly once.
REQ-035 Abort: run_en dropped on the first PULSE cycle -> btn_start_input=0 and run_state=0 next cycle; no flags set.
REQ-036 Tie and mid-run reset: quiet threshold and timeout coincide at cycle 100 -> DONE with run_timeout=0; reset asserted in RUN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: sequences one simulator run (delay, start pulse, wait for input, run until quiet) with a watchdog.
module sim_run_ctrl #(
  parameter logic [31:0] START_DELAY = 32'd16,
  parameter logic [7:0]  PULSE_LEN   = 8'd4,
  parameter logic [15:0] STOP_THRESH = 16'd255,
  parameter logic [31:0] TIMEOUT     = 32'd1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_en,
  input  logic [2:0]  pnl_pu_state,
  input  logic        pnl_input_active,
  input  logic        pnl_output_active,
  output logic        btn_start_input,
  output logic        machine_is_stop,
  output logic        run_timeout,
  output logic [2:0]  run_state,
  output logic [31:0] cycle_count
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DELAY   = 3'd1,
    PULSE   = 3'd2,
    WAIT_IN = 3'd3,
    RUN     = 3'd4,
    DONE    = 3'd5,
    TMO     = 3'd6
  } state_t;
  state_t      r_state, w_next;
  logic [31:0] r_delay, r_cnt;
  logic [7:0]  r_pulse;
  logic [15:0] r_quiet;
  logic        r_btn, r_stop, r_tmo;
  logic        w_quiet, w_active, w_next_active, w_stop_hit;
  assign w_quiet       = pnl_pu_state == 3'o0 && !pnl_input_active && !pnl_output_active;
  assign w_active      = r_state inside {DELAY, PULSE, WAIT_IN, RUN};
  assign w_next_active = w_next inside {DELAY, PULSE, WAIT_IN, RUN};
  assign w_stop_hit    = r_state == RUN && r_quiet == STOP_THRESH;
  // Priority in active states: abort, then stop, then watchdog; stop wins a tie with the watchdog.
  always_comb begin
    w_next = r_state;
    case (r_state)
      DELAY:     w_next = r_delay == START_DELAY ? PULSE : DELAY;
      PULSE:     w_next = r_pulse == PULSE_LEN - 8'd1 ? WAIT_IN : PULSE;
      WAIT_IN:   w_next = pnl_input_active ? RUN : WAIT_IN;
      RUN:       w_next = w_stop_hit ? DONE : RUN;
      DONE, TMO: w_next = run_en ? r_state : IDLE;
      default:   w_next = run_en ? DELAY : IDLE;
    endcase
    if (w_active && !run_en)
      w_next = IDLE;
    else if (w_active && !w_stop_hit && r_cnt == TIMEOUT)
      w_next = TMO;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_delay <= '0;
      r_pulse <= '0;
      r_quiet <= '0;
      r_cnt   <= '0;
      r_btn   <= 1'b0;
      r_stop  <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_delay <= r_state == DELAY ? r_delay + 32'd1 : '0;
      r_pulse <= r_state == PULSE ? r_pulse + 8'd1 : '0;
      r_quiet <= r_state == RUN && w_quiet ? r_quiet + 16'd1 : '0;
      r_cnt   <= w_next == IDLE ? '0 :
                 (w_active && w_next_active && r_cnt != 32'hFFFF_FFFF) ? r_cnt + 32'd1 : r_cnt;
      r_btn   <= w_next == PULSE;
      r_stop  <= w_next == DONE;
      r_tmo   <= w_next == TMO;
    end
  end
  assign btn_start_input = r_btn;
  assign machine_is_stop = r_stop;
  assign run_timeout     = r_tmo;
  assign run_state       = r_state;
  assign cycle_count     = r_cnt;
endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb_sim_run_ctrl: directed checks of sim_run_ctrl with START_DELAY=4, PULSE_LEN=2, STOP_THRESH=8, TIMEOUT=100.
module tb_sim_run_ctrl;
  logic        clk = 1'b0;
  logic        reset, run_en, ia, oa;
  logic [2:0]  pu;
  logic        btn, stop, tmo;
  logic [2:0]  st;
  logic [31:0] cnt;
  int checks = 0;
  int errors = 0;
  int pulses, highs;
  logic prev;

  sim_run_ctrl #(
    .START_DELAY(32'd4),
    .PULSE_LEN  (8'd2),
    .STOP_THRESH(16'd8),
    .TIMEOUT    (32'd100)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .run_en           (run_en),
    .pnl_pu_state     (pu),
    .pnl_input_active (ia),
    .pnl_output_active(oa),
    .btn_start_input  (btn),
    .machine_is_stop  (stop),
    .run_timeout      (tmo),
    .run_state        (st),
    .cycle_count      (cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] e_st, input logic e_btn,
                         input logic e_stop, input logic e_tmo, input logic [31:0] e_cnt);
    chk({tag, ".state"}, {29'd0, st}, {29'd0, e_st});
    chk({tag, ".btn"}, {31'd0, btn}, {31'd0, e_btn});
    chk({tag, ".stop"}, {31'd0, stop}, {31'd0, e_stop});
    chk({tag, ".tmo"}, {31'd0, tmo}, {31'd0, e_tmo});
    chk({tag, ".cnt"}, cnt, e_cnt);
  endtask

  initial begin
    reset = 1'b1; run_en = 1'b0; pu = 3'o1; ia = 1'b0; oa = 1'b0;
    tick(2);
    chk_all("reset", 3'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    reset = 1'b0;
    #2 run_en = 1'b1;
    #2 run_en = 1'b0;
    tick(1);
    chk_all("glitch", 3'd0, 1'b0, 1'b0, 1'b0, 32'd0);

    // nominal run
    run_en = 1'b1;
    tick(1);
    chk_all("nom.e0", 3'd1, 1'b0, 1'b0, 1'b0, 32'd0);
    tick(4);
    chk_all("nom.e4", 3'd1, 1'b0, 1'b0, 1'b0, 32'd4);
    tick(1);
    chk_all("nom.e5", 3'd2, 1'b1, 1'b0, 1'b0, 32'd5);
    tick(1);
    chk_all("nom.e6", 3'd2, 1'b1, 1'b0, 1'b0, 32'd6);
    tick(1);
    chk_all("nom.e7", 3'd3, 1'b0, 1'b0, 1'b0, 32'd7);
    ia = 1'b1;
    tick(1);
    chk_all("nom.e8", 3'd4, 1'b0, 1'b0, 1'b0, 32'd8);
    tick(9);
    ia = 1'b0; pu = 3'o0;
    tick(8);
    chk_all("nom.e25", 3'd4, 1'b0, 1'b0, 1'b0, 32'd25);
    tick(1);
    chk_all("nom.done", 3'd5, 1'b0, 1'b1, 1'b0, 32'd25);
    tick(3);
    chk_all("nom.hold", 3'd5, 1'b0, 1'b1, 1'b0, 32'd25);
    run_en = 1'b0;
    tick(1);
    chk_all("nom.idle", 3'd0, 1'b0, 1'b0, 1'b0, 32'd0);

    // quiet interruption
    pu = 3'o1; run_en = 1'b1;
    tick(8);
    ia = 1'b1;
    tick(1);
    ia = 1'b0; pu = 3'o0;
    tick(5);
    chk_all("qi.q5", 3'd4, 1'b0, 1'b0, 1'b0, 32'd13);
    pu = 3'o1;
    tick(1);
    pu = 3'o0;
    tick(8);
    chk_all("qi.e22", 3'd4, 1'b0, 1'b0, 1'b0, 32'd22);
    tick(1);
    chk_all("qi.done", 3'd5, 1'b0, 1'b1, 1'b0, 32'd22);
    run_en = 1'b0;
    tick(1);
    chk_all("qi.idle", 3'd0, 1'b0, 1'b0, 1'b0, 32'd0);

    // watchdog
    pu = 3'o1; run_en = 1'b1;
    pulses = 0; highs = 0; prev = 1'b0;
    for (int i = 0; i <= 100; i++) begin
      tick(1);
      if (btn && !prev) pulses++;
      if (btn) highs++;
      prev = btn;
    end
    chk_all("wd.e100", 3'd3, 1'b0, 1'b0, 1'b0, 32'd100);
    tick(1);
    chk_all("wd.tmo", 3'd6, 1'b0, 1'b0, 1'b1, 32'd100);
    chk("wd.pulses", pulses, 32'd1);
    chk("wd.highs", highs, 32'd2);
    tick(2);
    chk_all("wd.hold", 3'd6, 1'b0, 1'b0, 1'b1, 32'd100);
    run_en = 1'b0;
    tick(1);
    chk_all("wd.idle", 3'd0, 1'b0, 1'b0, 1'b0, 32'd0);

    // abort on first PULSE cycle
    run_en = 1'b1;
    tick(6);
    chk_all("ab.pulse", 3'd2, 1'b1, 1'b0, 1'b0, 32'd5);
    run_en = 1'b0;
    tick(1);
    chk_all("ab.idle", 3'd0, 1'b0, 1'b0, 1'b0, 32'd0);

    // stop threshold and timeout coincide
    run_en = 1'b1;
    tick(8);
    ia = 1'b1;
    tick(85);
    chk_all("tie.e92", 3'd4, 1'b0, 1'b0, 1'b0, 32'd92);
    ia = 1'b0; pu = 3'o0;
    tick(8);
    chk_all("tie.e100", 3'd4, 1'b0, 1'b0, 1'b0, 32'd100);
    tick(1);
    chk_all("tie.done", 3'd5, 1'b0, 1'b1, 1'b0, 32'd100);
    run_en = 1'b0;
    tick(1);

    // reset in RUN, then reset in PULSE
    pu = 3'o1; run_en = 1'b1;
    tick(8);
    ia = 1'b1;
    tick(3);
    chk_all("rst.run", 3'd4, 1'b0, 1'b0, 1'b0, 32'd10);
    reset = 1'b1;
    tick(1);
    chk_all("rst.after_run", 3'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    reset = 1'b0; ia = 1'b0;
    tick(6);
    chk_all("rst.pulse", 3'd2, 1'b1, 1'b0, 1'b0, 32'd5);
    reset = 1'b1;
    tick(1);
    chk_all("rst.after_pulse", 3'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    reset = 1'b0; run_en = 1'b0;
    tick(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
